// File: rtl/cond_pkg.sv
// Shared condition encodings and flag bit positions for the condition handler.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condition_handler_if.sv
// Pipeline-side signal bundle of the condition handler (ID/EX inputs, PC/flush controls out).
interface condition_handler_if;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       store_cc;
  logic       id_b;
  logic       id_bl;
  logic [3:0] cc;
  logic       cond_true;
  logic       branch;
  logic       branch_link;
  logic       stall;
  logic       nop_ex;

  modport master (
    output cond, alu_flags, store_cc, id_b, id_bl,
    input  cc, cond_true, branch, branch_link, stall, nop_ex
  );

  modport slave (
    input  cond, alu_flags, store_cc, id_b, id_bl,
    output cc, cond_true, branch, branch_link, stall, nop_ex
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition code against {N,Z,C,V}.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/condition_handler.sv
// Flag register plus branch/stall/squash control for the ID stage.
// Build option CC_BYPASS_EN forwards EX-stage flags instead of stalling.
module condition_handler
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  condition_handler_if.slave    bus
);

  logic [3:0] cc_q;
  logic [3:0] eff_flags;
  logic       cond_true;
  logic       stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_q <= RESET_FLAGS;
    end else if (bus.store_cc) begin
      cc_q <= bus.alu_flags;
    end
  end

`ifdef CC_BYPASS_EN
  assign eff_flags = bus.store_cc ? bus.alu_flags : cc_q;
  assign stall     = 1'b0;
`else
  // AL never depends on flags, so it can proceed past a flag-setting EX instruction.
  assign eff_flags = cc_q;
  assign stall     = bus.store_cc & (bus.cond != COND_AL);
`endif

  cond_eval u_cond_eval (
    .cond      (bus.cond),
    .flags     (eff_flags),
    .cond_true (cond_true)
  );

  assign bus.cc          = cc_q;
  assign bus.cond_true   = cond_true;
  assign bus.stall       = stall;
  assign bus.branch      = bus.id_b  & cond_true & !stall;
  assign bus.branch_link = bus.id_bl & cond_true & !stall;
  assign bus.nop_ex      = !cond_true & !stall;

endmodule

// File: tb/tb_condition_handler.sv
// Directed-vector scoreboard bench for condition_handler (either CC_BYPASS_EN build).
module tb_condition_handler;

  typedef struct {
    string      name;
    logic [3:0] cc;
    logic       ct;
    logic       b;
    logic       bl;
    logic       st;
    logic       nop;
  } exp_t;

  logic clk;
  logic reset_n;
  logic strobe;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  condition_handler_if bus ();

  condition_handler #(.RESET_FLAGS(4'b0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Monitor: on each strobe, pop the oldest expectation and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge strobe);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        e = sb_q.pop_front();
        chk({e.name, ".cc"},          bus.cc,                   e.cc);
        chk({e.name, ".cond_true"},   {3'b000, bus.cond_true},   {3'b000, e.ct});
        chk({e.name, ".branch"},      {3'b000, bus.branch},      {3'b000, e.b});
        chk({e.name, ".branch_link"}, {3'b000, bus.branch_link}, {3'b000, e.bl});
        chk({e.name, ".stall"},       {3'b000, bus.stall},       {3'b000, e.st});
        chk({e.name, ".nop_ex"},      {3'b000, bus.nop_ex},      {3'b000, e.nop});
      end
    end
  end

  task automatic drive(input logic [3:0] cond, input logic [3:0] alu,
                       input logic sc, input logic b, input logic bl);
    bus.cond      = cond;
    bus.alu_flags = alu;
    bus.store_cc  = sc;
    bus.id_b      = b;
    bus.id_bl     = bl;
  endtask

  task automatic expect_now(input string name, input logic [3:0] cc, input logic ct,
                            input logic b, input logic bl, input logic st, input logic nop);
    exp_t e;
    #1;
    e.name = name; e.cc = cc; e.ct = ct; e.b = b; e.bl = bl; e.st = st; e.nop = nop;
    sb_q.push_back(e);
    strobe = 1'b1;
    #1;
    strobe = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_cc(input logic [3:0] f);
    drive(4'b1110, f, 1'b1, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    strobe   = 1'b0;
    reset_n  = 1'b0;
    drive(4'b1110, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    next_cycle();
    expect_now("reset_hold", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    reset_n = 1'b1;
    drive(4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_now("reset_release", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    load_cc(4'b0100);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_now("eq_branch", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_now("ne_squash", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    load_cc(4'b1000);
    drive(4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0);
    expect_now("lt_true", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b1100, 4'b0000, 1'b0, 1'b0, 1'b0);
    expect_now("gt_false", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    load_cc(4'b0010);
    drive(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_now("hi_true", 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_now("ls_false", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    load_cc(4'b0000);
    drive(4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1);
    expect_now("al_link", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
    expect_now("nv_squash", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flag-setting EX instruction in the same cycle as a conditional branch in ID.
    drive(4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0);
`ifdef CC_BYPASS_EN
    expect_now("hazard_bypass", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    expect_now("hazard_stall", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_now("hazard_after", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    load_cc(4'b1111);
    drive(4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    expect_now("pre_async", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    expect_now("async_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
